// File: rtl/output_capture_fifo.sv
// output_capture_fifo
//   Captures processor output words (p_o) on every flag-high cycle into a
//   DEPTH-entry FIFO, tagging each with a TAG_W-bit sequence number. Captures
//   that arrive while the FIFO is full (and not being popped) are dropped and
//   counted.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-low reset
//   p_o        in   32-bit word to capture
//   flag       in   capture strobe, one capture per high cycle
//   out_data   out  head-of-FIFO data word (0 when empty after reset)
//   out_tag    out  head-of-FIFO sequence tag
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accepts head when high with out_valid
//   count      out  occupancy 0..DEPTH
//   full       out  count == DEPTH
//   overflow   out  sticky: a capture was dropped since reset
//   drop_cnt   out  saturating count of dropped captures
module output_capture_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                p_o,
  input  logic                       flag,
  output logic [31:0]                out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]      r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic [TAG_W-1:0] r_seq;
  logic             r_overflow;
  logic [15:0]      r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // When full, a same-cycle pop frees the slot the write lands in (wr == rd).
  assign w_push  = flag && (!w_full || w_pop);
  assign w_drop  = flag && w_full && !w_pop;

  // Storage is cleared on reset so out_data/out_tag read 0 right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= p_o;
      r_mem_tag[r_wr_ptr]  <= r_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      // Sequence advances on every capture attempt, accepted or dropped.
      if (flag) begin
        r_seq <= r_seq + TAG_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_tag   = r_mem_tag[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/output_capture_fifo.md
OUTPUT_CAPTURE_FIFO -- requirements
Module: output_capture_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries; power of two, 2..64.
REQ-002 Parameter TAG_W, default 8, meaning width of capture sequence tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 p_o  input  32  processor output word from the output select stage.
REQ-006 flag  input  1  high = p_o valid this cycle; one capture per high cycle.
REQ-007 out_data  output  32  head-of-FIFO data word.
REQ-008 out_tag  output  TAG_W  sequence tag of head entry.
REQ-009 out_valid  output  1  head entry valid (FIFO not empty).
REQ-010 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 full  output  1  count == DEPTH.
REQ-013 overflow  output  1  sticky: at least one capture dropped since reset.
REQ-014 drop_cnt  output  16  number of captures dropped, saturating.

Function
REQ-015 Push: on a rising edge with reset high and flag high, the FIFO SHALL write {p_o, seq} at the write pointer if not full after accounting for same-cycle pop.
REQ-016 seq SHALL be a TAG_W-bit counter, incremented by 1 on every flag-high cycle (accepted or dropped), wrapping from all-ones to 0.
REQ-017 Pop: on a rising edge with out_valid and out_ready both high, the head entry SHALL be removed and the read pointer advanced.
REQ-018 out_valid SHALL equal (count != 0); out_data/out_tag SHALL be registered storage at the read pointer, stable while out_valid high and out_ready low.
REQ-019 Latency: a word pushed into an empty FIFO SHALL appear on out_data with out_valid high on the cycle after the push edge; no same-cycle bypass.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: both SHALL occur, count unchanged.
REQ-022 Full with simultaneous pop and push: push SHALL be accepted (pop frees the slot), count stays DEPTH, no drop.
REQ-023 Full with push and no pop: capture SHALL be dropped, storage unchanged, overflow set to 1, drop_cnt incremented unless already 16'hFFFF.
REQ-024 Empty with out_ready high and no push: no state change; count SHALL never underflow.
REQ-025 out_ready while out_valid low SHALL be ignored.
REQ-026 flag low SHALL cause no write and no seq increment regardless of p_o value.
REQ-027 Control state is the occupancy: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions only by REQ-015..REQ-023, at most one step per cycle.

Reset
REQ-028 reset low at a rising edge SHALL force: write/read pointers 0, count 0, seq 0, overflow 0, drop_cnt 0, out_valid 0, full 0.
REQ-029 out_data and out_tag SHALL read 0 during and immediately after reset (storage contents need not be cleared except as required for this).
REQ-030 reset asserted mid-operation SHALL discard all stored entries; push and pop in the reset cycle SHALL be ignored.
REQ-031 First push after reset release SHALL carry tag 0.

Verification
REQ-032 Reset, then flag high 1 cycle with p_o=32'hDEADBEEF, out_ready=0 -> next cycle out_valid=1, out_data=32'hDEADBEEF, out_tag=0, count=1.
REQ-033 DEPTH=8, out_ready=0, 10 consecutive flag-high cycles with p_o=1..10 -> full=1, count=8, overflow=1, drop_cnt=2; then out_ready=1 drains 1..8 with tags 0..7, then out_valid=0.
REQ-034 Full FIFO, one cycle flag=1 p_o=32'h55 and out_ready=1 -> head popped, 32'h55 stored at tail, count=8, drop_cnt unchanged.
REQ-035 Continuous flag=1 and out_ready=1 for 300 cycles -> count oscillates only 0/1, no drops, tags wrap 255->0 in order.
REQ-036 Load 5 entries, assert reset low for 1 cycle while flag=1 and out_ready=1 -> count=0, out_valid=0, overflow=0, next accepted capture has tag 0.
